// File: rtl/seg7_pattern_decoder.sv
// Seven-segment pattern decoder: debounces an active-low segment bus and reports each newly
// stable pattern as a 4-bit code over valid/ready. Optional error counter: SEG7_DEC_ERRCNT_EN.
module seg7_pattern_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [6:0] seg_in,
    output logic [3:0] out_code,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready
`ifdef SEG7_DEC_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_EMIT   = 2'd2;

    localparam logic [6:0] PAT_BLANK = 7'b1111111;
    localparam logic [3:0] CODE_BLANK = 4'd14;
    localparam logic [7:0] CNT_LAST  = 8'(STABLE_CYCLES - 1);

    // Index in this table is the display code it decodes to.
    localparam logic [6:0] CODE_PAT [15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0001110, 7'b1111111
    };

    logic [6:0]  seg_q;
    logic [6:0]  last_pat_reg;
    logic [6:0]  cand_reg;
    logic [7:0]  cnt_reg;
    logic [1:0]  state_reg;

    logic [14:0] match;
    logic [3:0]  dec_code;
    logic        dec_err;
    logic        enter_emit;

    // Whenever EMIT is entered, cand equals seg_q, so decoding seg_q is sufficient.
    for (genvar gi = 0; gi < 15; gi++) begin : g_match
        assign match[gi] = (seg_q == CODE_PAT[gi]);
    end

    always_comb begin
        dec_code = 4'd15;
        for (int i = 0; i < 15; i++) begin
            if (match[i]) begin
                dec_code = 4'(i);
            end
        end
        dec_err = ~|match;
    end

    always_comb begin
        enter_emit = 1'b0;
        case (state_reg)
            ST_IDLE:   enter_emit = (seg_q != last_pat_reg) && (STABLE_CYCLES == 1);
            ST_SETTLE: enter_emit = (seg_q != last_pat_reg) && (seg_q == cand_reg)
                                    && (cnt_reg == CNT_LAST);
            default:   enter_emit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            seg_q        <= PAT_BLANK;
            last_pat_reg <= PAT_BLANK;
            cand_reg     <= PAT_BLANK;
            cnt_reg      <= 8'd0;
            state_reg    <= ST_IDLE;
            out_code     <= CODE_BLANK;
            out_err      <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            seg_q <= seg_in;
            case (state_reg)
                ST_IDLE: begin
                    if (seg_q != last_pat_reg) begin
                        cand_reg  <= seg_q;
                        cnt_reg   <= 8'd1;
                        state_reg <= enter_emit ? ST_EMIT : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (seg_q == last_pat_reg) begin
                        state_reg <= ST_IDLE;
                    end else if (seg_q != cand_reg) begin
                        cand_reg <= seg_q;
                        cnt_reg  <= 8'd1;
                    end else if (enter_emit) begin
                        state_reg <= ST_EMIT;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            if (enter_emit) begin
                out_code     <= dec_code;
                out_err      <= dec_err;
                last_pat_reg <= seg_q;
                out_valid    <= 1'b1;
            end
        end
    end

`ifdef SEG7_DEC_ERRCNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_count <= 8'd0;
        end else if (enter_emit && dec_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Directed bench for seg7_pattern_decoder: table of decode vectors plus hand sequences for
// glitch rejection, back-pressure, reset during EMIT and error-count saturation.
module tb_seg7_pattern_decoder;

    logic       clk;
    logic       resetn;
    logic [6:0] seg_in;
    logic [3:0] out_code;
    logic       out_err;
    logic       out_valid;
    logic       out_ready;
`ifdef SEG7_DEC_ERRCNT_EN
    logic [7:0] err_count;
`endif

    seg7_pattern_decoder #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .seg_in    (seg_in),
        .out_code  (out_code),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SEG7_DEC_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] seg;
        int         code;
        int         err;
    } vec_t;

    vec_t vecs [17];
    int   nvec = 0;
    int   nerr = 0;
    int   exp_ecnt = 0;

    task automatic chk(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (out_valid) break;
        end
        chk({name, "_valid"}, int'(out_valid), 1);
    endtask

    task automatic no_emit(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (out_valid) seen = 1;
        end
        chk(name, seen, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int held;

        vecs[0]  = '{7'b1000000, 0, 0};
        vecs[1]  = '{7'b1111001, 1, 0};
        vecs[2]  = '{7'b0100100, 2, 0};
        vecs[3]  = '{7'b0110000, 3, 0};
        vecs[4]  = '{7'b0011001, 4, 0};
        vecs[5]  = '{7'b0010010, 5, 0};
        vecs[6]  = '{7'b0000010, 6, 0};
        vecs[7]  = '{7'b1111000, 7, 0};
        vecs[8]  = '{7'b0000000, 8, 0};
        vecs[9]  = '{7'b0010000, 9, 0};
        vecs[10] = '{7'b0001000, 10, 0};
        vecs[11] = '{7'b0000011, 11, 0};
        vecs[12] = '{7'b1000110, 12, 0};
        vecs[13] = '{7'b0001110, 13, 0};
        vecs[14] = '{7'b1111111, 14, 0};
        vecs[15] = '{7'b0101010, 15, 1};
        vecs[16] = '{7'b1010101, 15, 1};

        resetn    = 1'b0;
        seg_in    = 7'b1111111;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_code", int'(out_code), 14);
        chk("rst_err", int'(out_err), 0);
        chk("rst_valid", int'(out_valid), 0);
`ifdef SEG7_DEC_ERRCNT_EN
        chk("rst_errcnt", int'(err_count), 0);
`endif
        resetn = 1'b1;

        // Blank bus after reset matches last_pat: nothing to report.
        no_emit("blank_no_emit", 20);
        chk("blank_code", int'(out_code), 14);

        // Two-cycle glitch that returns to blank is swallowed.
        seg_in = 7'b0110000;
        tick();
        tick();
        seg_in = 7'b1111111;
        no_emit("glitch_no_emit", 20);

        seg_in = 7'b0010010;
        wait_valid("code5", n);
        chk("code5_code", int'(out_code), 5);
        $display("txn glitch-then-5 seg=%b code=%0d err=%0d", seg_in, out_code, out_err);
        no_emit("code5_single", 20);

        // Latency: valid rises after edge STABLE_CYCLES+1 and lasts one cycle.
        seg_in = 7'b0100100;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 4) chk("lat_edge4_valid", int'(out_valid), 0);
        end
        chk("lat_edge5_valid", int'(out_valid), 1);
        chk("lat_code", int'(out_code), 2);
        chk("lat_err", int'(out_err), 0);
        $display("txn latency seg=%b code=%0d err=%0d", seg_in, out_code, out_err);
        tick();
        chk("lat_one_cycle", int'(out_valid), 0);

        for (int v = 0; v < 17; v++) begin
            seg_in = vecs[v].seg;
            wait_valid("tbl", n);
            chk("tbl_latency", n, 5);
            chk("tbl_code", int'(out_code), vecs[v].code);
            chk("tbl_err", int'(out_err), vecs[v].err);
            if (vecs[v].err != 0 && exp_ecnt < 255) exp_ecnt++;
`ifdef SEG7_DEC_ERRCNT_EN
            chk("tbl_errcnt", int'(err_count), exp_ecnt);
`endif
            $display("txn vec %0d seg=%b code=%0d err=%0d", v, seg_in, out_code, out_err);
            tick();
            chk("tbl_pulse", int'(out_valid), 0);
        end

        // Back-pressure: 9 held while the bus walks 8 -> 7; only 7 follows.
        out_ready = 1'b0;
        seg_in    = 7'b0010000;
        wait_valid("bp9", n);
        chk("bp9_code", int'(out_code), 9);
        seg_in = 7'b0000000;
        repeat (3) tick();
        seg_in = 7'b1111000;
        held = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || out_code != 4'd9) held = 0;
        end
        chk("bp9_held", held, 1);
        $display("txn backpressure seg=0010000 code=%0d err=%0d", out_code, out_err);
        out_ready = 1'b1;
        tick();
        chk("bp_accept", int'(out_valid), 0);
        wait_valid("bp7", n);
        chk("bp7_code", int'(out_code), 7);
        $display("txn after-accept seg=%b code=%0d err=%0d", seg_in, out_code, out_err);
        no_emit("bp8_dropped", 20);

`ifdef SEG7_DEC_ERRCNT_EN
        for (int i = 0; i < 256; i++) begin
            seg_in = (i % 2 == 0) ? 7'b0101010 : 7'b1010101;
            wait_valid("sat", n);
            tick();
            if (exp_ecnt < 255) exp_ecnt++;
        end
        chk("sat_errcnt", int'(err_count), exp_ecnt);
        $display("txn saturation err_count=%0d", err_count);
`endif

        // Reset while a result is pending, then re-emission of the same bus value.
        out_ready = 1'b0;
        seg_in    = 7'b0011001;
        wait_valid("rst4", n);
        chk("rst4_code", int'(out_code), 4);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_valid", int'(out_valid), 0);
        chk("async_code", int'(out_code), 14);
`ifdef SEG7_DEC_ERRCNT_EN
        chk("async_errcnt", int'(err_count), 0);
`endif
        #1;
        resetn    = 1'b1;
        out_ready = 1'b1;
        wait_valid("reemit", n);
        chk("reemit_latency", n, 5);
        chk("reemit_code", int'(out_code), 4);
        $display("txn reemit seg=%b code=%0d err=%0d", seg_in, out_code, out_err);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
